// File: rtl/bench_resp_misr.sv
// Response compactor: folds benchmark output words into a MISR signature and compares it with a golden value.
// Optional watchdog abort on a stalled response stream is enabled with `define BIST_TIMEOUT_EN.
module bench_resp_misr #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY  = 32'h04C11DB7,
    parameter logic [WIDTH-1:0] SEED  = 32'hFFFFFFFF,
    parameter int               CNT_W = 16,
    parameter int               TO_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_patterns,
    input  logic [WIDTH-1:0] golden_sig,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp_data,
    output logic             resp_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [WIDTH-1:0] golden_q, golden_d;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;

    function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] s,
                                                    input logic [WIDTH-1:0] d);
        return {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? POLY : '0) ^ d;
    endfunction

`ifdef BIST_TIMEOUT_EN
    logic [TO_W-1:0] wd_q, wd_d;
    logic            to_q, to_d;
    localparam logic [TO_W-1:0] WD_LAST = {{(TO_W-1){1'b1}}, 1'b0};
`endif

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        golden_d = golden_q;
        sig_d    = sig_q;
        count_d  = count_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
`ifdef BIST_TIMEOUT_EN
        wd_d     = wd_q;
        to_d     = to_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    target_d = num_patterns;
                    golden_d = golden_sig;
                    sig_d    = SEED;
                    count_d  = '0;
                    pass_d   = 1'b0;
                    fail_d   = 1'b0;
`ifdef BIST_TIMEOUT_EN
                    wd_d     = '0;
                    to_d     = 1'b0;
`endif
                    state_d  = (num_patterns == '0) ? CHECK : RUN;
                end
            end
            RUN: begin
                // resp_ready is constant 1 here, so resp_valid alone marks an accepted beat
                if (resp_valid) begin
                    sig_d   = misr_step(sig_q, resp_data);
                    count_d = count_q + CNT_W'(1);
`ifdef BIST_TIMEOUT_EN
                    wd_d    = '0;
`endif
                    if (count_q == target_q - CNT_W'(1))
                        state_d = CHECK;
                end
`ifdef BIST_TIMEOUT_EN
                else if (wd_q == WD_LAST) begin
                    // this is the (2^TO_W-1)th consecutive idle cycle
                    pass_d  = 1'b0;
                    fail_d  = 1'b1;
                    to_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    wd_d = wd_q + TO_W'(1);
                end
`endif
            end
            CHECK: begin
                pass_d  = (sig_q == golden_q);
                fail_d  = (sig_q != golden_q);
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            target_q <= '0;
            golden_q <= '0;
            sig_q    <= SEED;
            count_q  <= '0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            golden_q <= golden_d;
            sig_q    <= sig_d;
            count_q  <= count_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
        end
    end

`ifdef BIST_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
            to_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            to_q <= to_d;
        end
    end

    assign timeout = to_q;
`else
    // constant 0: no watchdog in this build
    assign timeout = (TO_W < 0);
`endif

    assign resp_ready = (state_q == RUN);
    assign busy       = (state_q == RUN) || (state_q == CHECK);
    assign done       = (state_q == DONE);
    assign pass       = pass_q;
    assign fail       = fail_q;
    assign signature  = sig_q;
    assign count      = count_q;

endmodule

// File: tb/tb_bench_resp_misr.sv
// Self-checking bench for bench_resp_misr: constant vectors, randomized runs against a
// signature model, and hand-written gap/start/reset/timeout sequences.
module tb_bench_resp_misr;

    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam logic [31:0] SEED = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_patterns = '0;
    logic [31:0] golden_sig = '0;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_data = '0;
    logic        resp_ready, busy, done, pass, fail, timeout;
    logic [31:0] signature;
    logic [15:0] count;

    int n_cmp = 0;
    int n_bad = 0;

    bench_resp_misr dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_patterns(num_patterns),
        .golden_sig(golden_sig), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_ready(resp_ready), .busy(busy), .done(done), .pass(pass), .fail(fail),
        .timeout(timeout), .signature(signature), .count(count)
    );

    always #5 clk = ~clk;

    // Reference: signature of a whole response stream, polynomial division style.
    function automatic logic [31:0] model_sig(input logic [31:0] words[$]);
        logic [31:0] s = SEED;
        foreach (words[i]) s = (s << 1) ^ (s[31] ? POLY : 32'h0) ^ words[i];
        return s;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] n, input logic [31:0] g);
        start = 1'b1; num_patterns = n; golden_sig = g;
        tick();
        start = 1'b0;
    endtask

    // Sends words with optional idle gaps; a stray start pulse may be dropped into each gap.
    task automatic send(input logic [31:0] words[$], input int max_gap, input bit poke_start);
        foreach (words[i]) begin
            int gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int j = 0; j < gap; j++) begin
                resp_data = $urandom;
                if (poke_start) begin
                    start = 1'b1; num_patterns = 16'd7; golden_sig = $urandom;
                end
                tick();
                start = 1'b0;
            end
            resp_valid = 1'b1; resp_data = words[i];
            tick();
            resp_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input string name);
        int b = 0;
        while (!done && b < 6) begin tick(); b++; end
        chk({name, "_done"}, done, 1'b1);
    endtask

    typedef struct {
        logic [15:0] n;
        logic [31:0] golden;
        logic [31:0] data;
        logic [31:0] exp_sig;
        logic        exp_pass;
    } vec_t;

    initial begin
        vec_t vecs[4];
        logic [31:0] q[$];
        logic [31:0] ref_sig;

        vecs[0] = '{16'd1, 32'hFB3EE249, 32'h00000000, 32'hFB3EE249, 1'b1};
        vecs[1] = '{16'd1, 32'hFB3EE249, 32'hFFFFFFFF, 32'h04C11DB6, 1'b0};
        vecs[2] = '{16'd0, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 1'b1};
        vecs[3] = '{16'd0, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 1'b0};

        // Reset state
        repeat (2) tick();
        chk("rst_ready", resp_ready, 0); chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);        chk("rst_pass", pass, 0);
        chk("rst_fail", fail, 0);        chk("rst_timeout", timeout, 0);
        chk("rst_sig", signature, SEED); chk("rst_count", count, 0);
        rst_n = 1'b1;
        tick();

        // resp_valid in IDLE is not consumed
        resp_valid = 1'b1; resp_data = 32'hDEADBEEF;
        repeat (2) tick();
        resp_valid = 1'b0;
        chk("idle_valid_sig", signature, SEED);
        chk("idle_valid_count", count, 0);
        chk("idle_valid_busy", busy, 0);

        // Table vectors with exact latency
        for (int i = 0; i < 4; i++) begin
            do_start(vecs[i].n, vecs[i].golden);
            if (vecs[i].n != 0) begin
                chk($sformatf("v%0d_ready", i), resp_ready, 1);
                resp_valid = 1'b1; resp_data = vecs[i].data;
                tick();
                resp_valid = 1'b0;
            end
            chk($sformatf("v%0d_ready_off", i), resp_ready, 0);
            chk($sformatf("v%0d_check_busy", i), {busy, done}, 2'b10);
            tick();
            chk($sformatf("v%0d_done", i), done, 1);
            chk($sformatf("v%0d_sig", i), signature, vecs[i].exp_sig);
            chk($sformatf("v%0d_pf", i), {pass, fail}, {vecs[i].exp_pass, ~vecs[i].exp_pass});
            chk($sformatf("v%0d_count", i), count, vecs[i].n);
        end

        // resp_valid in DONE: signature held
        ref_sig = signature;
        resp_valid = 1'b1; resp_data = 32'h0BADF00D;
        repeat (2) tick();
        resp_valid = 1'b0;
        chk("done_valid_sig", signature, ref_sig);
        chk("done_hold", done, 1);

        // Randomized runs against the model
        for (int r = 0; r < 10; r++) begin
            int n = $urandom_range(1, 12);
            bit good = $urandom_range(0, 1);
            q.delete();
            for (int k = 0; k < n; k++) q.push_back($urandom);
            ref_sig = model_sig(q);
            do_start(16'(n), good ? ref_sig : ref_sig ^ 32'h1);
            send(q, 2, 1'b1);
            wait_done($sformatf("rnd%0d", r));
            chk($sformatf("rnd%0d_sig", r), signature, ref_sig);
            chk($sformatf("rnd%0d_count", r), count, n);
            chk($sformatf("rnd%0d_pf", r), {pass, fail}, {good, ~good});
        end

        // 4-beat run: gapless vs gapped with start pokes gives the same signature
        q = '{32'h00000001, 32'h80000002, 32'h00000003, 32'hC0000004};
        ref_sig = model_sig(q);
        do_start(16'd4, ref_sig);
        send(q, 0, 1'b0);
        wait_done("gapless");
        chk("gapless_sig", signature, ref_sig);
        do_start(16'd4, ref_sig);
        resp_data = 32'h5555AAAA;
        repeat (3) tick();
        chk("gap_noaccept", count, 0);
        send(q, 3, 1'b1);
        wait_done("gapped");
        chk("gapped_sig", signature, ref_sig);
        chk("gapped_count", count, 4);
        chk("gapped_pass", {pass, fail}, 2'b10);

        // start during CHECK is ignored
        do_start(16'd1, 32'h0);
        resp_valid = 1'b1; resp_data = 32'h0;
        tick();
        resp_valid = 1'b0;
        start = 1'b1; num_patterns = 16'd9;
        tick();
        start = 1'b0;
        chk("chk_start_ignored", {done, fail}, 2'b11);
        chk("chk_start_sig", signature, 32'hFB3EE249);

        // Asynchronous reset mid-run
        do_start(16'd4, 32'h0);
        q = '{32'h11111111, 32'h22222222};
        send(q, 0, 1'b0);
        chk("mid_count", count, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_sig", signature, SEED);
        chk("arst_state", {resp_ready, busy, done}, 3'b000);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arst_idle", busy, 0);

`ifdef BIST_TIMEOUT_EN
        // Watchdog: 255 idle cycles in RUN abort the run
        do_start(16'd5, 32'h0);
        repeat (254) tick();
        chk("wd_not_yet", done, 0);
        tick();
        chk("wd_done", done, 1);
        chk("wd_flags", {pass, fail, timeout}, 3'b011);
        do_start(16'd0, SEED);
        chk("wd_timeout_cleared", timeout, 0);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
